// File: rtl/sms_pkg.sv
// ---------------------------------------------------------------------------
// sms_pkg
// Shared definitions for the SMS command controller:
//   - sms_state_e  : controller FSM state encoding
//   - STAT_*       : reply status codes for rejected commands
//   - MODE_*       : ASCII mode bytes understood by the controller
//   - RESET_PIN    : PIN value after reset ("0000")
//   - ASCII_*      : character constants used in reply formation
//   - LEN_W        : width of the received-length counter
//   - mode_is_valid: true for mode bytes '0'..'3'
// ---------------------------------------------------------------------------
package sms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV     = 3'd1,
    ST_CHECK    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_REPLY    = 3'd4,
    ST_WAIT_ACK = 3'd5
  } sms_state_e;

  localparam logic [7:0]  STAT_E      = 8'h45;  // 'E' wrong PIN
  localparam logic [7:0]  STAT_F      = 8'h46;  // 'F' malformed message
  localparam logic [7:0]  STAT_L      = 8'h4C;  // 'L' locked out

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_ZERO  = 8'h30;

  localparam logic [7:0]  MODE_SETPIN = 8'h30;  // '0'
  localparam logic [7:0]  MODE_ALARM  = 8'h31;  // '1'
  localparam logic [7:0]  MODE_MOTOR  = 8'h32;  // '2'
  localparam logic [7:0]  MODE_QUERY  = 8'h33;  // '3'

  localparam logic [31:0] RESET_PIN   = 32'h3030_3030;

  // Length counter is wide enough that any realistic over-long message
  // saturates rather than wrapping back into the "too short" range.
  localparam int LEN_W = 16;

  function automatic logic mode_is_valid(input logic [7:0] m);
    return (m >= MODE_SETPIN) && (m <= MODE_QUERY);
  endfunction

endpackage

// File: rtl/sms_msg_buf.sv
// ---------------------------------------------------------------------------
// sms_msg_buf
// Captures the bytes of one incoming SMS and counts its length.
// Bytes at index 0..MAX_BYTES-1 are stored; later bytes are only counted.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears the count)
//   clear_i      : synchronous clear of the length count (message consumed)
//   wr_en_i      : a byte is accepted this cycle
//   wr_byte_i    : the accepted byte
//   len_o        : number of bytes accepted in the current message
//   pin_o        : bytes 0..3, byte 0 in the most significant position
//   mode_o       : byte 4
//   new_pin_o    : bytes 5..8, byte 5 in the most significant position
// ---------------------------------------------------------------------------
module sms_msg_buf
  import sms_pkg::*;
#(
  parameter int MAX_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_byte_i,
  output logic [LEN_W-1:0] len_o,
  output logic [31:0]      pin_o,
  output logic [7:0]       mode_o,
  output logic [31:0]      new_pin_o
);

  // Storage always covers the nine decoded byte positions so the field
  // taps below stay in range even for a very small MAX_BYTES.
  localparam int DEPTH = (MAX_BYTES > 9) ? MAX_BYTES : 9;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_BYTES);

  logic [7:0]       mem_q [DEPTH];
  logic [LEN_W-1:0] len_q, len_d;
  logic             store;

  assign store = wr_en_i && (len_q < LEN_CAP);

  always_comb begin
    len_d = len_q;
    if (clear_i) begin
      len_d = '0;
    end else if (wr_en_i && (len_q != '1)) begin
      len_d = len_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  // Payload storage needs no reset: every field is qualified by len_q.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[len_q[IDX_W-1:0]] <= wr_byte_i;
    end
  end

  assign len_o     = len_q;
  assign pin_o     = {mem_q[0], mem_q[1], mem_q[2], mem_q[3]};
  assign mode_o    = mem_q[4];
  assign new_pin_o = {mem_q[5], mem_q[6], mem_q[7], mem_q[8]};

endmodule

// File: rtl/sms_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// sms_cmd_ctrl
// PIN-protected SMS command controller. Receives a message byte stream,
// checks PIN / length / mode, executes the command (set PIN, alarm strobe,
// motor toggle, status query), enforces a lockout after repeated PIN
// failures and hands a 128-bit reply word to the SMS send block.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_valid     : byte present on rx_byte
//   rx_byte      : ASCII message byte
//   rx_last      : rx_byte is the last byte of the message
//   rx_ready     : controller accepts a byte (IDLE and RECV only)
//   reply_code   : {pin[31:0], status[7:0], 8'h00, data[79:0]}
//   reply_valid  : reply_code is valid
//   reply_ack    : send block consumed the reply
//   motor_on     : motor drive state
//   alarm_pulse  : one-cycle alarm strobe
//   locked       : lockout active
//   dbg_state_o  : current FSM state
//
// Handshakes: a byte transfers on a rising edge where rx_valid and rx_ready
// are both high. A reply transfers on a rising edge where reply_valid and
// reply_ack are both high; reply_code and reply_valid hold until then, and
// reply_ack is ignored whenever reply_valid is low.
// ---------------------------------------------------------------------------
module sms_cmd_ctrl
  import sms_pkg::*;
#(
  parameter int MAX_BYTES   = 32,
  parameter int LOCK_CYCLES = 1000,
  parameter int MAX_FAILS   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         rx_last,
  output logic         rx_ready,
  output logic [127:0] reply_code,
  output logic         reply_valid,
  input  logic         reply_ack,
  output logic         motor_on,
  output logic         alarm_pulse,
  output logic         locked,
  output sms_state_e   dbg_state_o
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam int FAIL_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES);
  // Counter value at which one more 'E' triggers the lockout.
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);

  // ---------------------------------------------------------------- state
  sms_state_e        state_q, state_d;
  logic [31:0]       pin_q, pin_d;
  logic              motor_q, motor_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [7:0]        status_q, status_d;
  logic [127:0]      reply_q, reply_d;
  logic              reply_valid_q, reply_valid_d;

  // ------------------------------------------------------- message buffer
  logic             accept;
  logic             buf_clear;
  logic [LEN_W-1:0] buf_len;
  logic [31:0]      buf_pin;
  logic [7:0]       buf_mode;
  logic [31:0]      buf_new_pin;

  assign rx_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_RECV));
  assign accept   = rx_valid && rx_ready;

  sms_msg_buf #(
    .MAX_BYTES (MAX_BYTES)
  ) u_msg_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (buf_clear),
    .wr_en_i   (accept),
    .wr_byte_i (rx_byte),
    .len_o     (buf_len),
    .pin_o     (buf_pin),
    .mode_o    (buf_mode),
    .new_pin_o (buf_new_pin)
  );

  // ------------------------------------------------------- command check
  // Priority: lockout, then length, then PIN, then mode range.
  logic       msg_short;
  logic [7:0] chk_status;
  logic       chk_ok;
  logic       chk_pin_bad;

  assign msg_short = (buf_len < LEN_W'(5)) ||
                     ((buf_mode == MODE_SETPIN) && (buf_len < LEN_W'(9)));

  always_comb begin
    chk_status  = STAT_F;
    chk_ok      = 1'b0;
    chk_pin_bad = 1'b0;
    if (locked) begin
      chk_status = STAT_L;
    end else if (msg_short) begin
      chk_status = STAT_F;
    end else if (buf_pin != pin_q) begin
      chk_status  = STAT_E;
      chk_pin_bad = 1'b1;
    end else if (!mode_is_valid(buf_mode)) begin
      chk_status = STAT_F;
    end else begin
      chk_status = buf_mode;
      chk_ok     = 1'b1;
    end
  end

  // ------------------------------------------------------ reply data field
  // Only a successful query carries the motor state; status_q holds the
  // mode byte on success and an upper-case letter otherwise, so comparing
  // against '3' selects exactly that case.
  logic [79:0] reply_data;
  logic [7:0]  motor_char;

  assign motor_char = ASCII_ZERO + {7'd0, motor_q};
  assign reply_data = (status_q == MODE_QUERY) ? {motor_char, {9{ASCII_SPACE}}}
                                               : {10{ASCII_SPACE}};

  // -------------------------------------------------------- FSM next state
  always_comb begin
    state_d       = state_q;
    pin_d         = pin_q;
    motor_d       = motor_q;
    fail_d        = fail_q;
    lock_d        = (lock_q != '0) ? (lock_q - LOCK_W'(1)) : '0;
    status_d      = status_q;
    reply_d       = reply_q;
    reply_valid_d = reply_valid_q;
    buf_clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = rx_last ? ST_CHECK : ST_RECV;
        end
      end

      ST_RECV: begin
        if (accept && rx_last) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        status_d = chk_status;
        state_d  = chk_ok ? ST_EXEC : ST_REPLY;
        if (chk_pin_bad) begin
          if (fail_q == FAIL_LAST) begin
            fail_d = '0;
            lock_d = LOCK_LOAD;
          end else begin
            fail_d = fail_q + FAIL_W'(1);
          end
        end
      end

      ST_EXEC: begin
        fail_d  = '0;
        state_d = ST_REPLY;
        case (status_q)
          MODE_SETPIN: pin_d   = buf_new_pin;
          MODE_MOTOR:  motor_d = ~motor_q;
          default:     ;
        endcase
      end

      ST_REPLY: begin
        // pin_q already reflects any PIN change made in EXEC.
        reply_d       = {pin_q, status_q, 8'h00, reply_data};
        reply_valid_d = 1'b1;
        state_d       = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (reply_ack) begin
          reply_valid_d = 1'b0;
          buf_clear     = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pin_q         <= RESET_PIN;
      motor_q       <= 1'b0;
      fail_q        <= '0;
      lock_q        <= '0;
      status_q      <= 8'h00;
      reply_q       <= '0;
      reply_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pin_q         <= pin_d;
      motor_q       <= motor_d;
      fail_q        <= fail_d;
      lock_q        <= lock_d;
      status_q      <= status_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
    end
  end

  // -------------------------------------------------------------- outputs
  assign alarm_pulse = (state_q == ST_EXEC) && (status_q == MODE_ALARM);
  assign motor_on    = motor_q;
  assign locked      = (lock_q != '0);
  assign reply_code  = reply_q;
  assign reply_valid = reply_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sms_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sms_cmd_ctrl
// Directed and randomized bench for sms_cmd_ctrl. Expected replies come from
// a message-level reference model (PIN, motor, fail count, lockout window
// tracked as edge numbers) and are queued in exp_q.
// ---------------------------------------------------------------------------
module tb_sms_cmd_ctrl;
  import sms_pkg::*;

  localparam int MAXB = 32;
  localparam int LC   = 1000;
  localparam int MF   = 3;

  // ------------------------------------------------------ clock and reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_last = 1'b0;
  logic         rx_ready;
  logic [127:0] reply_code;
  logic         reply_valid;
  logic         reply_ack = 1'b0;
  logic         motor_on;
  logic         alarm_pulse;
  logic         locked;
  sms_state_e   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int alarm_cnt = 0;
  always @(negedge clk) if (alarm_pulse === 1'b1) alarm_cnt <= alarm_cnt + 1;

  sms_cmd_ctrl #(
    .MAX_BYTES   (MAXB),
    .LOCK_CYCLES (LC),
    .MAX_FAILS   (MF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_last     (rx_last),
    .rx_ready    (rx_ready),
    .reply_code  (reply_code),
    .reply_valid (reply_valid),
    .reply_ack   (reply_ack),
    .motor_on    (motor_on),
    .alarm_pulse (alarm_pulse),
    .locked      (locked),
    .dbg_state_o (dbg_state)
  );

  // ------------------------------------------------------------ scoreboard
  logic [127:0] exp_q[$];
  logic [7:0]   msg_q[$];
  int           n_assert = 0;
  int           n_fail   = 0;

  // reference model state
  logic [31:0]  m_pin;
  logic         m_motor;
  int           m_fail;
  bit           m_lock_valid;
  int           m_lock_edge;
  int           acc_edge;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pin        = 32'h3030_3030;
    m_motor      = 1'b0;
    m_fail       = 0;
    m_lock_valid = 1'b0;
    m_lock_edge  = 0;
    exp_q.delete();
  endtask

  // The timer is loaded on the edge that leaves CHECK (lock edge + 1) and
  // then stays non-zero for LC edges.
  function automatic bit exp_locked(input int e);
    return m_lock_valid && ((e - m_lock_edge) >= 1) && ((e - m_lock_edge) <= LC);
  endfunction

  task automatic model_msg(input int acc, output logic [7:0] st, output int ealarm);
    logic [79:0] data;
    logic [7:0]  mch;
    int          n;
    n      = msg_q.size();
    ealarm = 0;
    data   = {10{8'h20}};
    if (exp_locked(acc)) begin
      st = 8'h4C;
    end else if (n < 5 || (msg_q[4] == 8'h30 && n < 9)) begin
      st = 8'h46;
    end else if ({msg_q[0], msg_q[1], msg_q[2], msg_q[3]} != m_pin) begin
      st = 8'h45;
      m_fail++;
      if (m_fail == MF) begin
        m_fail       = 0;
        m_lock_valid = 1'b1;
        m_lock_edge  = acc;
      end
    end else if (msg_q[4] < 8'h30 || msg_q[4] > 8'h33) begin
      st = 8'h46;
    end else begin
      st     = msg_q[4];
      m_fail = 0;
      if (st == 8'h30) m_pin = {msg_q[5], msg_q[6], msg_q[7], msg_q[8]};
      if (st == 8'h31) ealarm = 1;
      if (st == 8'h32) m_motor = ~m_motor;
      if (st == 8'h33) begin
        mch  = m_motor ? 8'h31 : 8'h30;
        data = {mch, {9{8'h20}}};
      end
    end
    exp_q.push_back({m_pin, st, 8'h00, data});
  endtask

  // --------------------------------------------------------- driver tasks
  task automatic push4(input logic [31:0] w);
    msg_q.push_back(w[31:24]);
    msg_q.push_back(w[23:16]);
    msg_q.push_back(w[15:8]);
    msg_q.push_back(w[7:0]);
  endtask

  task automatic send_msg(input bit with_last);
    int gap;
    for (int i = 0; i < msg_q.size(); i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = msg_q[i];
      rx_last  = with_last && (i == msg_q.size() - 1);
      chk("rx_ready_in_recv", 128'(rx_ready), 128'(1));
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_last  = 1'b0;
    end
    acc_edge = cyc;
  endtask

  task automatic run_reply(input int hold);
    logic [7:0]   st;
    logic [127:0] er;
    int           ealarm, a0, lat, elat;
    a0 = alarm_cnt;
    model_msg(acc_edge, st, ealarm);
    lat = 0;
    // reply_ack toggles randomly while no reply is offered; it must be ignored
    while (reply_valid !== 1'b1 && lat < 20) begin
      reply_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    reply_ack = 1'b0;
    elat = (st == 8'h45 || st == 8'h46 || st == 8'h4C) ? 2 : 3;
    chk("latency", 128'(lat), 128'(elat));
    er = exp_q.pop_front();
    chk("reply_code", reply_code, er);
    chk("status", 128'(reply_code[95:88]), 128'(st));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_reply_code", reply_code, er);
      chk("hold_reply_valid", 128'(reply_valid), 128'(1));
      chk("hold_rx_ready", 128'(rx_ready), 128'(0));
    end
    reply_ack = 1'b1;
    @(posedge clk);
    #1;
    reply_ack = 1'b0;
    chk("valid_after_ack", 128'(reply_valid), 128'(0));
    chk("ready_after_ack", 128'(rx_ready), 128'(1));
    chk("alarm_count", 128'(alarm_cnt - a0), 128'(ealarm));
    chk("motor_on", 128'(motor_on), 128'(m_motor));
    chk("locked", 128'(locked), 128'(exp_locked(cyc)));
  endtask

  task automatic do_msg(input int hold);
    send_msg(1'b1);
    run_reply(hold);
    msg_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 128'(rx_ready), 128'(0));
    chk({tag, "_reply_valid"}, 128'(reply_valid), 128'(0));
    chk({tag, "_reply_code"}, reply_code, 128'(0));
    chk({tag, "_motor_on"}, 128'(motor_on), 128'(0));
    chk({tag, "_alarm"}, 128'(alarm_pulse), 128'(0));
    chk({tag, "_locked"}, 128'(locked), 128'(0));
  endtask

  task automatic random_msg();
    int          n;
    logic [31:0] p;
    n = $urandom_range(1, 12);
    p = ($urandom_range(0, 3) != 0) ? m_pin
        : {8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9)),
           8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9))};
    push4(p);
    msg_q.push_back(8'h30 + 8'($urandom_range(0, 4)));
    for (int i = 0; i < 8; i++) msg_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
    while (msg_q.size() > n) void'(msg_q.pop_back());
    do_msg($urandom_range(0, 4));
  endtask

  // -------------------------------------------------------------- sequence
  initial begin
    model_reset();
    #2;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 128'(rx_ready), 128'(1));

    // "0000" '2' -> motor toggles on, reply held while ack withheld
    push4(32'h3030_3030); msg_q.push_back(8'h32);
    do_msg(6);

    // set PIN to "4321", then query shows motor '1'
    push4(32'h3030_3030); msg_q.push_back(8'h30); push4(32'h3433_3231);
    do_msg(1);
    push4(32'h3433_3231); msg_q.push_back(8'h33);
    do_msg(0);
    chk("query_top_byte", 128'(m_motor ? 8'h31 : 8'h30), 128'(8'h31));

    // three wrong PINs -> lockout, correct PIN rejected with 'L'
    for (int i = 0; i < 3; i++) begin
      push4(32'h3939_3939); msg_q.push_back(8'h33);
      do_msg(0);
    end
    chk("locked_after_fails", 128'(locked), 128'(1));
    push4(32'h3433_3231); msg_q.push_back(8'h33);
    do_msg(0);

    // wait out the lockout, then a correct PIN succeeds
    repeat (LC + 5) @(posedge clk);
    #1;
    chk("lock_expired", 128'(locked), 128'(0));
    push4(32'h3433_3231); msg_q.push_back(8'h33);
    do_msg(0);

    // too-short message
    push4(32'h3030_3030); void'(msg_q.pop_back());
    do_msg(0);

    // back to "0000", then a 40-byte alarm message
    push4(32'h3433_3231); msg_q.push_back(8'h30); push4(32'h3030_3030);
    do_msg(0);
    push4(32'h3030_3030); msg_q.push_back(8'h31);
    for (int i = 0; i < 35; i++) msg_q.push_back(8'h41 + 8'(i % 26));
    do_msg(0);

    // ack withheld for 50 cycles
    push4(32'h3030_3030); msg_q.push_back(8'h33);
    do_msg(50);

    // randomized messages against the model
    for (int r = 0; r < 25; r++) random_msg();

    // reset in RECV: partial motor command must have no effect
    push4(m_pin); msg_q.push_back(8'h32);
    send_msg(1'b0);
    msg_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_recv");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_motor_after_recv_reset", 128'(motor_on), 128'(0));
    chk("no_reply_after_recv_reset", 128'(reply_valid), 128'(0));

    // reset in WAIT_ACK
    push4(32'h3030_3030); msg_q.push_back(8'h33);
    send_msg(1'b1);
    msg_q.delete();
    for (int w = 0; w < 20 && reply_valid !== 1'b1; w++) begin
      @(posedge clk);
      #1;
    end
    chk("reply_before_wait_reset", 128'(reply_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_wait_ack");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // clean message after reset: query shows motor '0'
    push4(32'h3030_3030); msg_q.push_back(8'h33);
    do_msg(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sms_cmd_ctrl.md
SMS_CMD_CTRL -- requirements
Module: sms_cmd_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 32, meaning the maximum number of message bytes stored.
REQ-002 SHALL have parameter LOCK_CYCLES, default 1000, meaning the lockout duration in clk cycles.
REQ-003 SHALL have parameter MAX_FAILS, default 3, meaning the number of consecutive PIN failures that triggers lockout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_valid, input, 1 bit: a received SMS byte is present.
REQ-007 SHALL have port rx_byte, input, 8 bits: ASCII message byte.
REQ-008 SHALL have port rx_last, input, 1 bit: qualifies the final byte of a message.
REQ-009 SHALL have port rx_ready, output, 1 bit: controller accepts a byte.
REQ-010 SHALL have port reply_code, output, 128 bits: reply word for the SMS send block.
REQ-011 SHALL have port reply_valid, output, 1 bit: reply_code is valid.
REQ-012 SHALL have port reply_ack, input, 1 bit: the send block consumed the reply.
REQ-013 SHALL have port motor_on, output, 1 bit: motor drive state.
REQ-014 SHALL have port alarm_pulse, output, 1 bit: one-cycle signal strobe.
REQ-015 SHALL have port locked, output, 1 bit: lockout active.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, CHECK, EXEC, REPLY and WAIT_ACK.
REQ-017 SHALL raise rx_ready only in IDLE and RECV; a byte transfers when rx_valid and rx_ready are both high.
REQ-018 SHALL move from IDLE to RECV on the first accepted byte, and store each byte at index 0..MAX_BYTES-1.
REQ-019 SHALL drop bytes beyond MAX_BYTES, counting them but not storing them; processing of the message continues.
REQ-020 SHALL move to CHECK on an accepted byte with rx_last high; this includes a single-byte message sent from IDLE.
REQ-021 SHALL define the message layout as: bytes 0-3 = PIN (ASCII); byte 4 = mode ASCII '0'..'3'; bytes 5-8 = new PIN (mode 0 only).
REQ-022 SHALL assign the CHECK status code in this priority order:
  - locked -> 'L' (8'h4C);
  - length <5, or mode 0 with length <9 -> 'F' (8'h46);
  - PIN mismatch -> 'E' (8'h45);
  - mode byte outside '0'..'3' -> 'F'.
REQ-023 SHALL take exactly one cycle in CHECK; an error code goes to REPLY, otherwise the FSM goes to EXEC.
REQ-024 SHALL take exactly one cycle in EXEC and perform the mode action:
  - '0' -> pin register := bytes 5-8;
  - '1' -> alarm_pulse high for exactly that cycle;
  - '2' -> motor_on toggles;
  - '3' -> no state change.
REQ-025 SHALL increment the fail counter on each 'E' and clear it on any successful EXEC; when it reaches MAX_FAILS, lockout starts, the counter clears and the lock timer loads LOCK_CYCLES.
REQ-026 SHALL decrement the lock timer every cycle in every state; locked is high while the timer is non-zero, and the timer saturates at 0.
REQ-027 SHALL form reply_code as {pin[31:0], status[7:0], 8'h00, data[79:0]}:
  - status = mode byte on success, else the error code;
  - pin = the register value after EXEC.
REQ-028 SHALL set data to {8'h30+motor_on, 72 bits of 8'h20} for mode '3', and to ten bytes of 8'h20 otherwise.
REQ-029 SHALL latch reply_code in REPLY, assert reply_valid from WAIT_ACK entry, and hold both stable until reply_ack; the FSM returns to IDLE in the cycle after the ack.
REQ-030 SHALL ignore reply_ack while reply_valid is low.
REQ-031 SHALL give a latency of 3 cycles from the accepted rx_last to reply_valid high (CHECK, EXEC, REPLY), or 2 cycles on the error path.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force:
  - state = IDLE; pin = 32'h30303030 ("0000");
  - motor_on, alarm_pulse, reply_valid, locked = 0; rx_ready = 0 while reset is asserted;
  - fail counter, lock timer, byte count = 0; reply_code = 0.
REQ-033 SHALL discard any partial message or pending reply on reset mid-operation, with no EXEC side effects.

Structure
REQ-034 SHALL place the FSM state encoding, the status codes ('E','F','L'), the reset PIN and the ASCII space/zero constants in shared package sms_pkg.
REQ-035 SHALL implement message byte capture plus length counting as sub-module sms_msg_buf; the FSM, PIN check, lockout and reply formation live in sms_cmd_ctrl.

Verification
REQ-036 SHALL cover: reset, then "0000" '2' -> motor_on 0->1; reply status 8'h32; reply_valid held until the ack.
REQ-037 SHALL cover: "00000" + "4321" (mode 0, 9 bytes) -> pin=32'h34333231; a following "4321" '3' -> data top byte 8'h31 when motor_on=1.
REQ-038 SHALL cover: three messages with PIN "9999" -> statuses 'E','E','E', locked high; a correct PIN within LOCK_CYCLES -> 'L'; after expiry -> success.
REQ-039 SHALL cover: a 3-byte message "000" -> 'F'; 40-byte "0000" '1' message -> alarm_pulse exactly one cycle, extra bytes dropped.
REQ-040 SHALL cover: reply_ack withheld 50 cycles -> rx_ready low and reply_code stable for all 50.
REQ-041 SHALL cover: rst_n low in RECV and again in WAIT_ACK -> outputs at reset values immediately; no motor toggle.
